// File: rtl/ram_dump_viewer_if.sv
// rtl/ram_dump_viewer_if.sv - read-only RAM port between the dump viewer and the data RAM
interface ram_dump_viewer_if;
    logic [7:0]  ram_addr;
    logic [15:0] ram_rdata;

    modport master (output ram_addr, input ram_rdata);
    modport slave  (input ram_addr, output ram_rdata);
endinterface

// File: rtl/ram_dump_viewer.sv
// rtl/ram_dump_viewer.sv - steps through the 256x16 data RAM and shows address/data on 8 seven-segment digits
module ram_dump_viewer #(
    parameter int         READ_LAT    = 1,
    parameter int         REFRESH_DIV = 12500,
    parameter int         AUTO_DIV    = 5000000,
    parameter logic [7:0] START_ADDR  = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               step_flag,
    input  logic               auto_mode,
    ram_dump_viewer_if.master  ram,
    output logic [7:0]         cur_addr,
    output logic [15:0]        cur_data,
    output logic               busy,
    output logic [7:0]         anode_select,
    output logic [6:0]         seg_select
);
    localparam logic [1:0]  LAT_LAST  = 2'(READ_LAT - 1);
    localparam logic [15:0] SCAN_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [23:0] AUTO_LAST = 24'(AUTO_DIV - 1);

    typedef enum logic [1:0] {IDLE, READ, SHOW} state_t;

    state_t      state, state_nx;
    logic [7:0]  addr;
    logic [1:0]  lat_cnt;
    logic [15:0] scan_cnt;
    logic [2:0]  digit;
    logic [23:0] auto_cnt;
    logic        tick, lat_done, step_go, capture;
    logic [3:0]  nibble;
    logic        blank_digit;
    logic [6:0]  seg_nx;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign ram.ram_addr = addr;
    assign busy         = (state == READ);

    // Disable wins over any capture or step in the same cycle; a step and a tick together advance once.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        step_go  = 1'b0;
        tick     = (state == SHOW) && auto_mode && (auto_cnt == AUTO_LAST);
        lat_done = (lat_cnt == LAT_LAST);
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = READ;
                READ: if (lat_done) begin
                    capture  = 1'b1;
                    state_nx = SHOW;
                end
                SHOW: if (step_flag || tick) begin
                    step_go  = 1'b1;
                    state_nx = READ;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        nibble      = 4'h0;
        blank_digit = 1'b0;
        case (digit)
            3'd7: nibble = cur_addr[7:4];
            3'd6: nibble = cur_addr[3:0];
            3'd3: nibble = cur_data[15:12];
            3'd2: nibble = cur_data[11:8];
            3'd1: nibble = cur_data[7:4];
            3'd0: nibble = cur_data[3:0];
            default: blank_digit = 1'b1;
        endcase
        seg_nx = blank_digit ? 7'h7F : hex7(nibble);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= START_ADDR;
            cur_addr     <= START_ADDR;
            cur_data     <= 16'h0000;
            lat_cnt      <= 2'd0;
            auto_cnt     <= 24'd0;
            scan_cnt     <= 16'd0;
            digit        <= 3'd0;
            anode_select <= 8'hFF;
            seg_select   <= 7'h7F;
        end else begin
            state <= state_nx;
            if (step_go) begin
                addr <= addr + 8'd1;
            end
            if (capture) begin
                cur_data <= ram.ram_rdata;
                cur_addr <= addr;
            end
            lat_cnt  <= (state == READ && !lat_done) ? lat_cnt + 2'd1 : 2'd0;
            auto_cnt <= (state == SHOW && auto_mode && !tick) ? auto_cnt + 24'd1 : 24'd0;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= 16'd0;
                digit    <= digit + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
            // Anode and segments are registered together so the pins switch on the same edge.
            anode_select <= (state == IDLE) ? 8'hFF : ~(8'h01 << digit);
            seg_select   <= (state == IDLE) ? 7'h7F : seg_nx;
        end
    end
endmodule

// File: tb/tb_ram_dump_viewer.sv
// tb/tb_ram_dump_viewer.sv - self-checking bench for ram_dump_viewer
module tb_ram_dump_viewer;
    localparam int         READ_LAT    = 1;
    localparam int         REFRESH_DIV = 4;
    localparam int         AUTO_DIV    = 8;
    localparam logic [7:0] START_ADDR  = 8'hFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        step_flag = 1'b0;
    logic        auto_mode = 1'b0;
    logic [7:0]  cur_addr;
    logic [15:0] cur_data;
    logic        busy;
    logic [7:0]  anode_select;
    logic [6:0]  seg_select;
    logic [15:0] mem [256];

    int n_chk = 0;
    int n_fail = 0;

    ram_dump_viewer_if ram_if ();
    assign ram_if.ram_rdata = mem[ram_if.ram_addr];

    ram_dump_viewer #(
        .READ_LAT(READ_LAT), .REFRESH_DIV(REFRESH_DIV),
        .AUTO_DIV(AUTO_DIV), .START_ADDR(START_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .step_flag(step_flag),
        .auto_mode(auto_mode), .ram(ram_if.master), .cur_addr(cur_addr),
        .cur_data(cur_data), .busy(busy), .anode_select(anode_select),
        .seg_select(seg_select)
    );

    always #5 clk = ~clk;

    // Reference: viewer is either off, waiting out a read, or showing; the display digit follows elapsed clocks.
    int          m_k, m_wait, m_auto;
    logic        m_active;
    logic [7:0]  m_addr, m_cur_addr, m_anode;
    logic [15:0] m_cur_data;
    logic [6:0]  m_seg;

    function automatic logic [6:0] font(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic logic [6:0] digit_seg(input int d, input logic [7:0] a, input logic [15:0] w);
        logic [31:0] shown;
        shown = {a, 8'h00, w};
        if (d == 4 || d == 5) return 7'h7F;
        return font(4'((shown >> (4 * d)) & 32'hF));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_k <= 0; m_active <= 1'b0; m_wait <= 0; m_auto <= 0;
            m_addr <= START_ADDR; m_cur_addr <= START_ADDR; m_cur_data <= 16'h0000;
            m_anode <= 8'hFF; m_seg <= 7'h7F;
        end else begin
            m_k     <= m_k + 1;
            m_anode <= m_active ? ~(8'h01 << ((m_k / REFRESH_DIV) % 8)) : 8'hFF;
            m_seg   <= m_active ? digit_seg((m_k / REFRESH_DIV) % 8, m_cur_addr, m_cur_data) : 7'h7F;
            if (!enable) begin
                m_active <= 1'b0; m_wait <= 0; m_auto <= 0;
            end else if (!m_active) begin
                m_active <= 1'b1; m_wait <= READ_LAT;
            end else if (m_wait != 0) begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) begin
                    m_cur_addr <= m_addr;
                    m_cur_data <= mem[m_addr];
                end
            end else if (step_flag || (auto_mode && m_auto == AUTO_DIV - 1)) begin
                m_addr <= m_addr + 8'd1; m_wait <= READ_LAT; m_auto <= 0;
            end else begin
                m_auto <= auto_mode ? m_auto + 1 : 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("model_ram_addr", ram_if.ram_addr, m_addr);
        chk("model_cur_addr", cur_addr, m_cur_addr);
        chk("model_cur_data", cur_data, m_cur_data);
        chk("model_busy", busy, m_active && m_wait != 0);
        chk("model_anode", anode_select, m_anode);
        chk("model_seg", seg_select, m_seg);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ram_addr"}, ram_if.ram_addr, START_ADDR);
        chk({tag, "_cur_addr"}, cur_addr, START_ADDR);
        chk({tag, "_cur_data"}, cur_data, 16'h0000);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_anode"}, anode_select, 8'hFF);
        chk({tag, "_seg"}, seg_select, 7'h7F);
    endtask

    typedef struct packed {
        logic        en, step, busy, blank;
        logic [7:0]  addr, cur_a;
        logic [15:0] cur_d;
    } vec_t;

    vec_t        vecs [13];
    logic [7:0]  prev_anode, exp_seg;
    int          run;
    bit          seen_change;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'hFE] = 16'hCAFE; mem[8'hFF] = 16'h5A5A;
        mem[8'h00] = 16'hBEEF; mem[8'h01] = 16'h0123;

        //          en  st  busy blank addr   cur_a  cur_d
        vecs[0]  = {1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 8'hFE, 16'h0000};
        vecs[1]  = {1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 8'hFE, 16'h0000};
        vecs[2]  = {1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 8'hFE, 16'hCAFE};
        vecs[3]  = {1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFE, 16'hCAFE};
        vecs[4]  = {1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 16'h5A5A};
        vecs[5]  = {1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 16'h5A5A};
        vecs[6]  = {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 16'h5A5A};
        vecs[7]  = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 16'h5A5A};
        vecs[8]  = {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 16'h5A5A};
        vecs[9]  = {1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 16'h5A5A};
        vecs[10] = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'hBEEF};
        vecs[11] = {1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 16'hBEEF};
        vecs[12] = {1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 16'h0123};

        cycle(); cycle();
        check_reset_values("reset");
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            enable = vecs[i].en; step_flag = vecs[i].step;
            cycle();
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_ram_addr", i), ram_if.ram_addr, vecs[i].addr);
            chk($sformatf("vec%0d_cur_addr", i), cur_addr, vecs[i].cur_a);
            chk($sformatf("vec%0d_cur_data", i), cur_data, vecs[i].cur_d);
            chk($sformatf("vec%0d_blank", i), anode_select == 8'hFF, vecs[i].blank);
        end
        step_flag = 1'b0;

        // Showing address 01 / data 0123: every digit has a known pattern and rotates every 4 clocks.
        prev_anode = anode_select; run = 1; seen_change = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            case (anode_select)
                8'hFE: exp_seg = 7'h30;
                8'hFD: exp_seg = 7'h24;
                8'hFB: exp_seg = 7'h79;
                8'hF7: exp_seg = 7'h40;
                8'hEF, 8'hDF: exp_seg = 7'h7F;
                8'hBF: exp_seg = 7'h79;
                default: exp_seg = 7'h40;
            endcase
            chk("digit_seg", seg_select, exp_seg);
            if (anode_select != prev_anode) begin
                if (seen_change) chk("scan_hold", run, 4);
                chk("scan_order", anode_select, {prev_anode[6:0], prev_anode[7]});
                seen_change = 1; run = 1;
            end else begin
                run++;
            end
            prev_anode = anode_select;
        end

        auto_mode = 1'b1;
        repeat (AUTO_DIV - 1) cycle();
        step_flag = 1'b1;
        cycle();
        step_flag = 1'b0;
        chk("step_with_tick_addr", ram_if.ram_addr, 8'h02);
        repeat (AUTO_DIV) cycle();
        chk("auto_before_tick", ram_if.ram_addr, 8'h02);
        chk("auto_capture_addr", cur_addr, 8'h02);
        cycle();
        chk("auto_tick_addr", ram_if.ram_addr, 8'h03);
        auto_mode = 1'b0;
        repeat (20) cycle();
        chk("auto_off_addr", ram_if.ram_addr, 8'h03);
        chk("auto_off_cur_data", cur_data, mem[8'h03]);

        step_flag = 1'b1;
        cycle();
        step_flag = 1'b0;
        chk("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        cycle();
        check_reset_values("reset_mid_read");
        rst = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            enable    = ($urandom_range(0, 19) != 0);
            step_flag = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) auto_mode = ~auto_mode;
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_dump_viewer.md
# ram_dump_viewer

Debug reader for the CPU's 256×16 data RAM. While the CPU is halted, it walks RAM addresses one per step pulse, or automatically at a fixed interval, and captures each word. It shows the address and data on the board's 8-digit seven-segment display. It sits beside the CPU on a second (read-only) RAM port. It takes its step pulse from a Key_Debounce instance and its enable from the CPU halt status.

## Interface
- READ_LAT, 1: RAM read latency in clocks, from address presented to data valid; legal range 1–3.
- REFRESH_DIV, 12500: clocks each display digit stays selected; legal range 2–65535.
- AUTO_DIV, 5000000: clocks between automatic steps in auto mode; legal range 2–2^24−1.
- START_ADDR, 8'h00: address loaded at reset.
- clk  input  1  system clock, the same clock as the CPU and RAM.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  viewer active; the CPU asserts it while halted.
- step_flag  input  1  one-cycle pulse from the debouncer; advances the address by +1.
- auto_mode  input  1  level; 1 = step automatically every AUTO_DIV clocks.
- ram_addr  output  8  read address to the RAM port.
- ram_rdata  input  16  read data from the RAM port.
- cur_addr  output  8  address of the word currently displayed.
- cur_data  output  16  captured data word currently displayed.
- busy  output  1  high while a read is in flight.
- anode_select  output  8  digit select, active low; bit i selects digit i.
- seg_select  output  7  segments, active low; bit 0 = a … bit 6 = g.

## Operation
- Address register and RAM port:
  - The address register `addr` drives ram_addr continuously.
  - cur_addr = address of the last completed capture.
- FSM states:
  - IDLE:
    - Entered at reset or when enable=0.
    - Display blanked: anode_select=8'hFF, seg_select=7'h7F.
    - enable rising → READ, with addr unchanged, so the current address is re-read.
  - READ:
    - Latency counter counts READ_LAT clocks.
    - On expiry: cur_data←ram_rdata, cur_addr←addr, go to SHOW.
    - busy=1 in READ only.
  - SHOW:
    - step_flag=1, or an auto tick when auto_mode=1 → addr←addr+1 (8-bit, 8'hFF wraps to 8'h00), go to READ.
- Steps arriving during READ are dropped, not queued.
- In any state, enable=0 forces IDLE on the next edge. This takes priority over a simultaneous step or capture.
- Auto tick:
  - Counts only in SHOW with auto_mode=1; cleared otherwise.
  - A tick fires when the count reaches AUTO_DIV−1, then the counter restarts.
  - step_flag and a tick in the same cycle produce one increment, not two.
- Display (enabled states READ/SHOW):
  - Digit index d cycles 0→7→0, advancing every REFRESH_DIV clocks; the scan counter free-runs in every state.
  - anode_select = ~(1<<d).
  - Digits 7..6 show cur_addr[7:4], [3:0].
  - Digits 5..4 are blank (seg 7'h7F).
  - Digits 3..0 show cur_data[15:12], [11:8], [7:4], [3:0].
- Hex font (active-low, g..a):
  - 0=7'h40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

## Timing
- Reset values:
  - addr=START_ADDR, cur_addr=START_ADDR, cur_data=16'h0000.
  - busy=0, FSM=IDLE, d=0.
  - scan and auto counters=0.
  - anode_select=8'hFF, seg_select=7'h7F.
- Step latency:
  - Step sampled at edge N (in SHOW) → ram_addr shows the new address after edge N.
  - cur_data/cur_addr update after edge N+READ_LAT; busy high for exactly READ_LAT cycles.
- Display outputs are registered, with one clock latency from d/cur_* to the pins.
- No glitching is permitted: both anode and segment outputs change on the same edge.
- Reset during READ: the capture is abandoned and all values return to their reset values on that edge.
- enable dropping during READ: no capture occurs. addr is kept, so re-enabling re-reads the same address.

## Test plan
- Reset, then enable=1 with RAM[0x00]=16'hBEEF and READ_LAT=1 → busy for 1 cycle, then cur_addr=8'h00, cur_data=16'hBEEF; digit 0 shows seg 7'h0E ("F") when anode=8'hFE.
- Scan check with REFRESH_DIV=4 → anode sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles; digits 4 and 5 show seg 7'h7F.
- Start at 8'hFE, three step pulses 10 cycles apart → cur_addr sequence FF, 00, 01 (wrap-around); cur_data matches RAM contents at each address.
- Step pulse during READ, and step coincident with an auto tick → exactly one increment in each case.
- Auto mode with AUTO_DIV=8 in SHOW → addr increments every 8+READ_LAT cycles; auto_mode=0 stops stepping immediately.
- enable=0 mid-READ, then re-enable → no capture while disabled, display blank; re-read of the same address; rst=1 mid-READ → all outputs at reset values on the next edge.
